// File: rtl/spm_mult_hs_pkg.sv
// Shared types and constants for the spm_mult_hs serial-parallel multiplier.
// Build option: define SPM_SIGNED_EN for two's-complement operands.
package spm_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spm_state_e;

  // Counter width able to hold 0 .. 2*width.
  function automatic int cnt_w(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/spm_mult_hs_if.sv
// Operand/product handshake bundle for spm_mult_hs.
// The multiplier is the slave; the producer/consumer side is the master.
interface spm_mult_hs_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/spm_csa_cell.sv
// One-bit carry-save cell of the serial-parallel multiplier chain.
// Adds the partial product x&y to the partial sum arriving from the next
// more significant cell and to its own stored carry. With TCMP set the
// partial product is complemented; the chain owner adds the matching
// constant so that the MSB weight of x becomes negative.
module spm_csa_cell #(
  parameter bit TCMP = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic x,
  input  logic y,
  input  logic s_in,
  output logic sum
);

  logic pp;
  logic sum_d;
  logic carry_q;
  logic carry_d;

  // Full-adder of partial product, incoming sum and stored carry.
  always_comb begin
    pp      = TCMP ? ~(x & y) : (x & y);
    sum_d   = pp ^ s_in ^ carry_q;
    carry_d = (pp & s_in) | (pp & carry_q) | (s_in & carry_q);
  end

  // Sum/carry flops: clear has priority, otherwise update only while enabled.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    if (clr) begin
      sum     <= 1'b0;
      carry_q <= 1'b0;
    end else if (en) begin
      sum     <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/spm_mult_hs.sv
// Serial-parallel multiplier with valid/ready operand and product handshakes.
// x is held in parallel, y is shifted LSB-first through a chain of WIDTH
// carry-save cells, and the product is collected LSB-first over 2*WIDTH
// cycles. Build option: define SPM_SIGNED_EN for a two's-complement product.
module spm_mult_hs
  import spm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  spm_mult_hs_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(PW - 1);

`ifdef SPM_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  spm_state_e       state_q;
  spm_state_e       state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_sr;
  logic [PW-2:0]    p_sr;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] s_in_v;

  logic in_ready_c;
  logic out_valid_c;
  logic busy_c;
  logic accept;
  logic run;
  logic cell_clr;
  logic y_fill;
  logic msb_s_in;

  assign accept   = in_ready_c & bus.in_valid;
  assign run      = (state_q == RUN);
  assign cell_clr = rst | accept;

  // Signed fill replicates the sign bit; the complemented MSB partial
  // products are balanced by adding 2^(WIDTH-1) once, in the first RUN cycle.
  assign y_fill   = SIGNED ? y_sr[WIDTH-1] : 1'b0;
  assign msb_s_in = SIGNED && (count_q == '0);
  assign s_in_v   = {msb_s_in, sum_q[WIDTH-1:1]};

  // Next state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (count_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        in_ready_c  = bus.out_ready;
        if (bus.out_ready) state_d = bus.in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // RUN cycle counter, restarted on every acceptance.
  always_ff @(posedge clk) begin
    if (rst || accept) count_q <= '0;
    else if (run)      count_q <= count_q + 1'b1;
  end

  // Operand capture, y serialisation and product collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= '0;
      y_sr <= '0;
      p_sr <= '0;
    end else if (accept) begin
      x_q  <= bus.x;
      y_sr <= bus.y;
    end else if (run) begin
      y_sr <= {y_fill, y_sr[WIDTH-1:1]};
      p_sr <= {sum_q[0], p_sr[PW-2:1]};
    end
  end

  // Cell chain: cell i receives the stored sum of cell i+1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    localparam bit IS_TCMP = SIGNED && (i == WIDTH - 1);
    spm_csa_cell #(
      .TCMP(IS_TCMP)
    ) u_cell (
      .clk (clk),
      .clr (cell_clr),
      .en  (run),
      .x   (x_q[i]),
      .y   (y_sr[0]),
      .s_in(s_in_v[i]),
      .sum (sum_q[i])
    );
  end

  // Cell 0 already holds the final product bit once the chain has run.
  assign bus.p         = {sum_q[0], p_sr};
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_spm_mult_hs.sv
// Self-checking bench for spm_mult_hs at WIDTH 2, 8 and 32.
// Honours SPM_SIGNED_EN in its reference model and directed values.
module tb_spm_mult_hs;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spm_mult_hs_if #(.WIDTH(2))  if2();
  spm_mult_hs_if #(.WIDTH(8))  if8();
  spm_mult_hs_if #(.WIDTH(32)) if32();

  spm_mult_hs #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(if2));
  spm_mult_hs #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  spm_mult_hs #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: true integer product of the operands, reduced mod 2^(2w).
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] prod;
    logic [63:0] mask;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
`ifdef SPM_SIGNED_EN
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
    prod = 64'(sa * sb);
    mask = (64'd1 << (2 * w)) - 64'd1;
    if (w == 32) mask = '1;
    return prod & mask;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] xa, input logic [31:0] ya);
    case (sel)
      2:       begin if2.in_valid = v;  if2.x = xa[1:0];  if2.y = ya[1:0];  end
      8:       begin if8.in_valid = v;  if8.x = xa[7:0];  if8.y = ya[7:0];  end
      default: begin if32.in_valid = v; if32.x = xa;      if32.y = ya;      end
    endcase
  endtask

  task automatic sample(input int sel, output logic ir, output logic ov, output logic bsy,
                        output logic [63:0] pp);
    case (sel)
      2:       begin ir = if2.in_ready;  ov = if2.out_valid;  bsy = if2.busy;  pp = 64'(if2.p);  end
      8:       begin ir = if8.in_ready;  ov = if8.out_valid;  bsy = if8.busy;  pp = 64'(if8.p);  end
      default: begin ir = if32.in_ready; ov = if32.out_valid; bsy = if32.busy; pp = 64'(if32.p); end
    endcase
  endtask

  // One full transaction from IDLE with out_ready high; latency, busy span and product checked.
  task automatic run_txn(input int sel, input logic [31:0] xa, input logic [31:0] ya,
                         input logic [63:0] exp, input string tag);
    int k;
    int busy_n;
    logic ir, ov, bsy;
    logic [63:0] pp;
    @(negedge clk);
    drive(sel, 1'b1, xa, ya);
    sample(sel, ir, ov, bsy, pp);
    check({tag, ".in_ready"}, 64'(ir), 64'd1);
    @(posedge clk);
    #1 drive(sel, 1'b0, 32'd0, 32'd0);
    k = 0;
    busy_n = 0;
    @(negedge clk);
    sample(sel, ir, ov, bsy, pp);
    while (!ov && k < 4 * sel + 8) begin
      busy_n += int'(bsy);
      @(negedge clk);
      k++;
      sample(sel, ir, ov, bsy, pp);
    end
    check({tag, ".latency"}, 64'(k), 64'(2 * sel));
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(2 * sel));
    check({tag, ".p"}, pp, exp);
    @(negedge clk);
    sample(sel, ir, ov, bsy, pp);
    check({tag, ".out_valid_after"}, 64'(ov), 64'd0);
  endtask

  logic        ir, ov, bsy;
  logic [63:0] pp;
  logic [63:0] p_hold;
  logic [63:0] exp_q[$];
  logic [31:0] ra, rb;
  logic [7:0]  px[4];
  logic [7:0]  py[4];
  int          k, n_acc, n_out, cyc, last_acc, cnt;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(2, 1'b0, 32'd0, 32'd0);
    drive(8, 1'b0, 32'd0, 32'd0);
    drive(32, 1'b0, 32'd0, 32'd0);
    if2.out_ready = 1'b1;
    if8.out_ready = 1'b1;
    if32.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    sample(8, ir, ov, bsy, pp);
    check("reset.in_ready", 64'(ir), 64'd1);
    check("reset.out_valid", 64'(ov), 64'd0);
    check("reset.busy", 64'(bsy), 64'd0);
    check("reset.p", pp, 64'd0);
    sample(32, ir, ov, bsy, pp);
    check("reset.p32", pp, 64'd0);
    rst = 1'b0;

    // Directed products at WIDTH=8
`ifdef SPM_SIGNED_EN
    run_txn(8, 32'd13, 32'd11, 64'h008F, "basic");
    run_txn(8, 32'hFD, 32'd5, 64'hFFF1, "neg3x5");
    run_txn(8, 32'h80, 32'h80, 64'h4000, "min_x_min");
    run_txn(8, 32'd0, 32'hC8, 64'h0000, "zero");
`else
    run_txn(8, 32'd13, 32'd11, 64'h008F, "basic");
    run_txn(8, 32'd255, 32'd255, 64'hFE01, "max_x_max");
    run_txn(8, 32'd0, 32'd200, 64'h0000, "zero");
`endif

    // Random products at WIDTH=8
    for (int i = 0; i < 6; i++) begin
      ra = $urandom & 32'hFF;
      rb = $urandom & 32'hFF;
      run_txn(8, ra, rb, ref_mul(8, ra, rb), "rand8");
    end

    // Backpressure: out_ready low for 5 cycles once the product is up
    if8.out_ready = 1'b0;
    ra = 32'd77;
    rb = 32'd201;
    @(negedge clk);
    drive(8, 1'b1, ra, rb);
    @(posedge clk);
    #1 drive(8, 1'b0, 32'd0, 32'd0);
    k = 0;
    @(negedge clk);
    sample(8, ir, ov, bsy, pp);
    while (!ov && k < 40) begin
      @(negedge clk);
      k++;
      sample(8, ir, ov, bsy, pp);
    end
    check("bp.latency", 64'(k), 64'd16);
    p_hold = pp;
    check("bp.p", p_hold, ref_mul(8, ra, rb));
    for (int i = 0; i < 5; i++) begin
      drive(8, (i % 2) == 0, $urandom, $urandom);
      @(negedge clk);
      sample(8, ir, ov, bsy, pp);
      check("bp.hold_valid", 64'(ov), 64'd1);
      check("bp.hold_in_ready", 64'(ir), 64'd0);
      check("bp.hold_p", pp, p_hold);
    end
    drive(8, 1'b0, 32'd0, 32'd0);
    if8.out_ready = 1'b1;
    @(negedge clk);
    sample(8, ir, ov, bsy, pp);
    check("bp.release_valid", 64'(ov), 64'd0);
    check("bp.release_in_ready", 64'(ir), 64'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sample(8, ir, ov, bsy, pp);
      cnt += int'(ov) + int'(bsy);
    end
    check("bp.no_extra_activity", 64'(cnt), 64'd0);

    // Back-to-back: in_valid held with fresh pairs, out_ready high
    for (int i = 0; i < 4; i++) begin
      px[i] = 8'($urandom);
      py[i] = 8'($urandom);
    end
    @(negedge clk);
    drive(8, 1'b1, 32'(px[0]), 32'(py[0]));
    n_acc = 0;
    n_out = 0;
    cyc = 0;
    last_acc = 0;
    while (n_out < 4 && cyc < 200) begin
      sample(8, ir, ov, bsy, pp);
      if (ov) begin
        check("b2b.p", pp, exp_q.pop_front());
        if (n_acc < 4) check("b2b.accept_with_output", 64'(ir), 64'd1);
        n_out++;
      end
      if (ir && n_acc < 4) begin
        exp_q.push_back(ref_mul(8, 32'(px[n_acc]), 32'(py[n_acc])));
        if (n_acc > 0) check("b2b.period", 64'(cyc - last_acc), 64'd17);
        last_acc = cyc;
        n_acc++;
        @(posedge clk);
        if (n_acc < 4) #1 drive(8, 1'b1, 32'(px[n_acc]), 32'(py[n_acc]));
        else           #1 drive(8, 1'b0, 32'd0, 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b.outputs", 64'(n_out), 64'd4);
    drive(8, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);

    // Reset during RUN aborts the product
    drive(8, 1'b1, 32'd9, 32'd7);
    @(posedge clk);
    #1 drive(8, 1'b0, 32'd0, 32'd0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sample(8, ir, ov, bsy, pp);
    check("rst_run.out_valid", 64'(ov), 64'd0);
    check("rst_run.p", pp, 64'd0);
    check("rst_run.busy", 64'(bsy), 64'd0);
    check("rst_run.in_ready", 64'(ir), 64'd1);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      sample(8, ir, ov, bsy, pp);
      cnt += int'(ov);
    end
    check("rst_run.no_valid", 64'(cnt), 64'd0);
    run_txn(8, 32'd2, 32'd3, 64'd6, "after_rst");

    // Width sweep
    for (int i = 0; i < 8; i++) begin
      ra = $urandom & 32'h3;
      rb = $urandom & 32'h3;
      run_txn(2, ra, rb, ref_mul(2, ra, rb), "w2");
    end
    run_txn(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ref_mul(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF), "w32_max");
    for (int i = 0; i < 5; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_txn(32, ra, rb, ref_mul(32, ra, rb), "w32");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
